// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM state type for the TDM receive demultiplexer.
package tdm_pkg;
    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_ch_shift.sv
// tdm_ch_shift: one channel's MSB-first word assembler, shifting din in on each enabled beat.
module tdm_ch_shift #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_din,
    output logic [WORD_W-1:0] o_word
);
    logic [WORD_W-1:0] r_word;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_word <= '0;
        else if (i_en) r_word <= {r_word[WORD_W-2:0], i_din};
    assign o_word = r_word;
endmodule

// File: rtl/tdm_demux_1_to_8.sv
// tdm_demux_1_to_8: bit-interleaved 8-channel TDM deserialiser with frame-sync tracking.
// Presents all channel words in parallel once per superframe of WORD_W frames.
import tdm_pkg::*;
module tdm_demux_1_to_8 #(
    parameter int WORD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [NUM_CH*WORD_W-1:0] ch_data,
    output logic                     out_valid,
    output logic                     locked,
    output logic                     sync_err
);
    localparam int FR_W = $clog2(WORD_W);
    state_t                   r_state;
    logic [SLOT_W-1:0]        r_slot;
    logic [FR_W-1:0]          r_frame;
    logic [NUM_CH*WORD_W-1:0] r_ch_data;
    logic                     r_out_valid, r_locked, r_sync_err;
    logic [WORD_W-1:0]        w_word [NUM_CH];
    logic [NUM_CH*WORD_W-1:0] w_latch;
    logic                     w_miss, w_early, w_cap, w_wrap, w_last;
    logic [SLOT_W-1:0]        w_dst;
    always_comb begin
        w_miss  = din_valid && r_state == LOCKED && r_slot == '0 && !frame_sync;
        w_early = din_valid && r_state == LOCKED && r_slot != '0 && frame_sync;
        w_cap   = din_valid && (r_state == LOCKED ? !w_miss : frame_sync);
        w_dst   = frame_sync ? '0 : r_slot;
        w_wrap  = r_slot == SLOT_W'(NUM_CH - 1);
        w_last  = w_cap && r_state == LOCKED && !w_early && w_wrap && r_frame == FR_W'(WORD_W - 1);
    end
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tdm_ch_shift #(.WORD_W(WORD_W)) u_shift (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_cap && w_dst == SLOT_W'(k)),
            .i_din (din),
            .o_word(w_word[k])
        );
        // the last channel is still shifting on the final beat, so latch its next value
        assign w_latch[k*WORD_W +: WORD_W] = (k == NUM_CH - 1) ? {w_word[k][WORD_W-2:0], din} : w_word[k];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_slot      <= '0;
            r_frame     <= '0;
            r_ch_data   <= '0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sync_err  <= w_miss || w_early;
            if (w_miss) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_slot   <= '0;
                r_frame  <= '0;
            end else if (w_cap && (r_state == HUNT || w_early)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_slot   <= SLOT_W'(1);
                r_frame  <= '0;
            end else if (w_cap) begin
                r_slot <= r_slot + 1'b1;
                if (w_wrap) r_frame <= (r_frame == FR_W'(WORD_W - 1)) ? '0 : r_frame + 1'b1;
                if (w_last) begin
                    r_ch_data   <= w_latch;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end
    assign ch_data   = r_ch_data;
    assign out_valid = r_out_valid;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;
endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
// tb_tdm_demux_1_to_8: table-driven superframes plus sync-error and reset sequences,
// with a queue of expected words popped whenever out_valid fires.
module tb_tdm_demux_1_to_8;
    localparam int W = 8;
    logic          clk = 1'b0;
    logic          rst, din, din_valid, frame_sync;
    logic [8*W-1:0] ch_data;
    logic          out_valid, locked, sync_err;
    int            n_cmp = 0, n_bad = 0, cyc = 0, ov_cyc = 0, ov_prev = 0;
    logic [8*W-1:0] q [$];
    typedef struct {
        logic [W-1:0]   w [8];
        bit             gap;
        logic [8*W-1:0] exp;
    } vec_t;
    vec_t          tbl [6];
    logic [W-1:0]  wa [8], wb [8], wc [8], wd [8], we [8], wf [8], wg [8], wh [8];

    tdm_demux_1_to_8 #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .frame_sync(frame_sync),
        .ch_data   (ch_data),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && out_valid) begin
            ov_prev = ov_cyc;
            ov_cyc  = cyc;
            if (q.size() == 0) chk("unexpected out_valid", 1, 0);
            else chk("scoreboard ch_data", ch_data, q.pop_front());
        end

    function automatic logic [8*W-1:0] pack(input logic [W-1:0] w [8]);
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = w[k];
        return r;
    endfunction

    task automatic rnd(output logic [W-1:0] w [8]);
        for (int k = 0; k < 8; k++) w[k] = W'($urandom);
    endtask

    task automatic beat(input logic d, input logic fs);
        din = d; frame_sync = fs; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beats(input logic [W-1:0] w [8], input int n, input bit gap, input bit exp_err, input bit push);
        for (int i = 0; i < n; i++) begin
            if (gap && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if (push && i == n - 1) q.push_back(pack(w));
            beat(w[i % 8][W - 1 - i / 8], (i % 8) == 0);
            if (i == 0) begin
                chk("locked after first beat", locked, 1);
                chk("sync_err after first beat", sync_err, exp_err);
                chk("out_valid after first beat", out_valid, 0);
            end
        end
    endtask

    task automatic send_sf(input logic [W-1:0] w [8], input bit gap, input bit exp_err);
        send_beats(w, 8 * W, gap, exp_err, 1);
        chk("out_valid after last beat", out_valid, 1);
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ch_data", ch_data, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset locked", locked, 0);
        chk("reset sync_err", sync_err, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) beat(1'($urandom), 1'b0);
        chk("hunt discards beats", locked, 0);

        for (int k = 0; k < 8; k++) begin
            tbl[0].w[k] = W'(8'h10 + k);
            tbl[1].w[k] = W'(8'h10 + k);
            tbl[3].w[k] = (k % 2) ? '1 : '0;
        end
        rnd(tbl[2].w); rnd(tbl[4].w); rnd(tbl[5].w);
        tbl[0].gap = 0; tbl[1].gap = 1; tbl[2].gap = 0;
        tbl[3].gap = 0; tbl[4].gap = 1; tbl[5].gap = 0;
        for (int i = 0; i < 6; i++) tbl[i].exp = pack(tbl[i].w);
        chk("known pattern constant", tbl[0].exp, 64'h1716151413121110);

        for (int i = 0; i < 6; i++) begin
            send_sf(tbl[i].w, tbl[i].gap, 0);
            chk("table ch_data", ch_data, tbl[i].exp);
            if (i == 3) chk("back-to-back period", ov_cyc - ov_prev, 8 * W);
        end
        idle(1);
        chk("out_valid single cycle", out_valid, 0);

        rnd(wa); rnd(wb);
        send_beats(wa, 19, 0, 0, 0);
        send_sf(wb, 0, 1);
        chk("ch_data after early sync", ch_data, pack(wb));

        rnd(wc); rnd(wd);
        send_beats(wc, 8 * W - 1, 0, 0, 0);
        send_sf(wd, 0, 1);
        chk("ch_data after final-beat early sync", ch_data, pack(wd));

        rnd(we); rnd(wf);
        send_beats(we, 40, 0, 0, 0);
        beat(1'b1, 1'b0);
        chk("missing sync sync_err", sync_err, 1);
        chk("missing sync locked", locked, 0);
        chk("missing sync ch_data held", ch_data, pack(wd));
        idle(1);
        chk("sync_err single cycle", sync_err, 0);
        send_sf(wf, 1, 0);
        chk("ch_data after relock", ch_data, pack(wf));

        rnd(wg); rnd(wh);
        send_beats(wg, 40, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async reset ch_data", ch_data, 0);
        chk("async reset locked", locked, 0);
        chk("async reset out_valid", out_valid, 0);
        chk("async reset sync_err", sync_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_sf(wh, 0, 0);
        chk("ch_data after reset", ch_data, pack(wh));

        idle(3);
        chk("scoreboard drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
